// File: rtl/bm_if_collapse_sink_pkg.sv
// Shared types and sizing helpers for the if-collapse result sink.
// Occupancy encoding is used by the FIFO; word width is derived from the operand width.
package bm_if_collapse_sink_pkg;

  localparam int BITS_DEF = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Packed result word is {out1, out2, out0}.
  function automatic int word_w(input int bits);
    return 2 * bits + 1;
  endfunction

endpackage

// File: rtl/bm_if_collapse_sink_if.sv
// Upstream result word plus the valid/ready drain port and status of the sink.
// master drives the upstream word and dout_ready; slave is the sink itself.
interface bm_if_collapse_sink_if
  import bm_if_collapse_sink_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int CNT_W = 8
);
  localparam int W = word_w(BITS);

  logic             in_valid;
  logic [BITS-1:0]  out0_in;
  logic [BITS-1:0]  out2_in;
  logic             out1_in;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             full;
  logic [CNT_W-1:0] change_cnt;
  logic             overflow;

  modport master (
    output in_valid, out0_in, out2_in, out1_in, dout_ready,
    input  dout, dout_valid, full, change_cnt, overflow
  );

  modport slave (
    input  in_valid, out0_in, out2_in, out1_in, dout_ready,
    output dout, dout_valid, full, change_cnt, overflow
  );
endinterface

// File: rtl/bm_if_collapse_sink_fifo.sv
// DEPTH x W first-word-fall-through FIFO; a push while full is accepted only when a pop frees a slot.
// dout/full/empty come from registers only; dout reads 0 while empty.
module bm_if_collapse_sink_fifo
  import bm_if_collapse_sink_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop_req,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         push_ok
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  occ_e          state, state_nxt;
  logic          pop;

  assign empty   = (state == OCC_EMPTY);
  assign full    = (state == OCC_FULL);
  assign pop     = pop_req & ~empty;
  assign push_ok = push & (~full | pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= OCC_EMPTY;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    count_nxt = count;
    state_nxt = state;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    case (state)
      OCC_EMPTY: begin
        if (push_ok && !pop) state_nxt = OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        if (count_nxt == CW'(DEPTH))  state_nxt = OCC_FULL;
        else if (count_nxt == '0)     state_nxt = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop && !push_ok) state_nxt = OCC_PARTIAL;
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end
endmodule

// File: rtl/bm_if_collapse_sink.sv
// Change-event sink: buffers a result word only when it differs from the last sampled word.
// One-cycle latency to dout when empty; events arriving while full (and not draining) are dropped and flagged.
module bm_if_collapse_sink
  import bm_if_collapse_sink_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  bm_if_collapse_sink_if.slave bus
);
  localparam int W = word_w(BITS);

  logic [W-1:0]     word, prev_word, fifo_dout;
  logic             prev_valid, change, push_ok, fifo_full, fifo_empty;
  logic [CNT_W-1:0] change_cnt;
  logic             overflow;

  assign word   = {bus.out1_in, bus.out2_in, bus.out0_in};
  assign change = bus.in_valid & (~prev_valid | (word != prev_word));

  bm_if_collapse_sink_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (change),
    .pop_req (bus.dout_ready),
    .din     (word),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok)
  );

  // prev tracks every sampled word, even ones that were dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_word  <= '0;
      prev_valid <= 1'b0;
      change_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        prev_word  <= word;
        prev_valid <= 1'b1;
      end
      if (change && (change_cnt != '1)) change_cnt <= change_cnt + CNT_W'(1);
      if (change && !push_ok) overflow <= 1'b1;
    end
  end

  assign bus.dout       = fifo_dout;
  assign bus.dout_valid = ~fifo_empty;
  assign bus.full       = fifo_full;
  assign bus.change_cnt = change_cnt;
  assign bus.overflow   = overflow;
endmodule
